// File: rtl/sram_ctrl_pkg.sv
// Shared constants and types for the banked SRAM controller.
package sram_ctrl_pkg;

    localparam int unsigned TILE_W  = 32;
    localparam int unsigned TILE_D  = 128;
    localparam int unsigned TILE_AW = $clog2(TILE_D);

    // Macro read-margin setting
    localparam logic [3:0] RM = 4'b0011;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } ctrl_state_e;

endpackage

// File: rtl/sram_macro_128x32.sv
// Behavioural model of the 128x32 hard macro: port A read/write with bit mask, port B write-only.
module sram_macro_128x32
    import sram_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic [3:0]         rm,
    input  logic               ce_a,
    input  logic               we_a,
    input  logic [TILE_AW-1:0] addr_a,
    input  logic [TILE_W-1:0]  wdata_a,
    input  logic [TILE_W-1:0]  bmask_a,
    output logic [TILE_W-1:0]  rdata_a,
    input  logic               ce_b,
    input  logic               we_b,
    input  logic [TILE_AW-1:0] addr_b,
    input  logic [TILE_W-1:0]  wdata_b,
    input  logic [TILE_W-1:0]  bmask_b
);

    logic [TILE_W-1:0] mem [TILE_D];

    // A zero read margin is not a valid macro setting; reads are suppressed
    always_ff @(posedge clk) begin
        if (ce_a && we_a) begin
            mem[addr_a] <= (mem[addr_a] & ~bmask_a) | (wdata_a & bmask_a);
        end
        if (ce_b && we_b) begin
            mem[addr_b] <= (mem[addr_b] & ~bmask_b) | (wdata_b & bmask_b);
        end
        if (ce_a && !we_a && (rm != 4'b0000)) begin
            rdata_a <= mem[addr_a];
        end
    end

endmodule

// File: rtl/sram_tile_array.sv
// ROWS x COLS grid of macros; one enable per row, second macro port tied off.
module sram_tile_array
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ROWS   = 4
) (
    input  logic                           clk,
    input  logic [ROWS-1:0]                row_en,
    input  logic                           we,
    input  logic [TILE_AW-1:0]             addr,
    input  logic [DATA_W-1:0]              wdata,
    input  logic [DATA_W-1:0]              bmask,
    output logic [ROWS-1:0][DATA_W-1:0]    rdata
);

    localparam int unsigned COLS = DATA_W / TILE_W;

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            sram_macro_128x32 u_macro (
                .clk     (clk),
                .rm      (RM),
                .ce_a    (row_en[r]),
                .we_a    (we),
                .addr_a  (addr),
                .wdata_a (wdata[c*TILE_W +: TILE_W]),
                .bmask_a (bmask[c*TILE_W +: TILE_W]),
                .rdata_a (rdata[r][c*TILE_W +: TILE_W]),
                .ce_b    (1'b0),
                .we_b    (1'b0),
                .addr_b  ({TILE_AW{1'b0}}),
                .wdata_b ({TILE_W{1'b0}}),
                .bmask_b ({TILE_W{1'b0}})
            );
        end
    end

endmodule

// File: rtl/sram_ctrl_banked.sv
// Banked SRAM controller: valid/ready requests, credit-checked response FIFO.
// Define SRAM_ZERO_INIT_EN to zero-fill the array after reset.
module sram_ctrl_banked
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned DEPTH     = 512,
    parameter int unsigned RSP_DEPTH = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_req_valid,
    output logic                     o_req_ready,
    input  logic                     i_req_we,
    input  logic [$clog2(DEPTH)-1:0] i_req_addr,
    input  logic [DATA_W-1:0]        i_req_wdata,
    input  logic [DATA_W-1:0]        i_req_bmask,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic [DATA_W-1:0]        o_rsp_rdata,
    output logic                     o_init_done
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned ROWS = DEPTH / TILE_D;
    localparam int unsigned RW   = $clog2(ROWS);
    localparam int unsigned PW   = $clog2(RSP_DEPTH);
    localparam int unsigned OW   = $clog2(RSP_DEPTH + 1);
    localparam int unsigned CW   = OW + 1;

    ctrl_state_e                 state_q, state_d;
    logic                        init_done_d;
    logic                        accept, rd_accept, pop, push;
    logic [RW-1:0]               req_row, rd_row_q;
    logic                        inflight_q;
    logic [OW-1:0]               occ_q, occ_d;
    logic [CW-1:0]               credit_c;
    logic [PW-1:0]               wr_ptr_q, rd_ptr_q;
    logic [RSP_DEPTH-1:0][DATA_W-1:0] fifo_q;
    logic [DATA_W-1:0]           push_data, head_d;
    logic [ROWS-1:0]             row_en;
    logic                        arr_we;
    logic [TILE_AW-1:0]          arr_addr;
    logic [DATA_W-1:0]           arr_wdata, arr_bmask;
    logic [ROWS-1:0][DATA_W-1:0] rdata_rows;
`ifdef SRAM_ZERO_INIT_EN
    logic [TILE_AW-1:0]          init_cnt_q;
`endif

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign req_row = i_req_addr[AW-1:TILE_AW];

    // Credit check counts in-flight reads so the FIFO can never overflow
    always_comb begin
        pop         = o_rsp_valid && i_rsp_ready;
        push        = inflight_q;
        credit_c    = CW'(occ_q) + CW'(inflight_q) - CW'(pop);
        o_req_ready = o_init_done && (credit_c < CW'(RSP_DEPTH));
        accept      = i_req_valid && o_req_ready;
        rd_accept   = accept && !i_req_we;
        occ_d       = occ_q + OW'(push) - OW'(pop);
    end

    always_comb begin
        state_d     = state_q;
        init_done_d = o_init_done;
        case (state_q)
`ifdef SRAM_ZERO_INIT_EN
            ST_INIT: if (init_cnt_q == TILE_AW'(TILE_D - 1)) state_d = ST_RUN;
`else
            ST_INIT: state_d = ST_RUN;
`endif
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
`ifdef SRAM_ZERO_INIT_EN
        init_done_d = (state_d == ST_RUN);
`else
        init_done_d = (state_q == ST_RUN);
`endif
    end

    // Array port drive: accepted request, or the zero-fill sweep during INIT
    always_comb begin
        row_en    = '0;
        arr_we    = 1'b0;
        arr_addr  = i_req_addr[TILE_AW-1:0];
        arr_wdata = i_req_wdata;
        arr_bmask = i_req_bmask;
        if (accept) begin
            row_en = ROWS'(1) << req_row;
            arr_we = i_req_we;
        end
`ifdef SRAM_ZERO_INIT_EN
        if (state_q == ST_INIT) begin
            row_en    = '1;
            arr_we    = 1'b1;
            arr_addr  = init_cnt_q;
            arr_wdata = '0;
            arr_bmask = '1;
        end
`endif
    end

    // Next FIFO head, kept in a register so o_rsp_rdata is a flop output
    always_comb begin
        push_data = rdata_rows[rd_row_q];
        head_d    = o_rsp_rdata;
        if ((occ_q == '0) || (pop && (occ_q == OW'(1)))) begin
            if (push) head_d = push_data;
        end else if (pop) begin
            head_d = fifo_q[ptr_inc(rd_ptr_q)];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_INIT;
            o_init_done <= 1'b0;
            inflight_q  <= 1'b0;
            rd_row_q    <= '0;
            occ_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_q      <= '0;
            o_rsp_valid <= 1'b0;
            o_rsp_rdata <= '0;
        end else begin
            state_q     <= state_d;
            o_init_done <= init_done_d;
            inflight_q  <= rd_accept;
            if (rd_accept) rd_row_q <= req_row;
            if (push) begin
                fifo_q[wr_ptr_q] <= push_data;
                wr_ptr_q         <= ptr_inc(wr_ptr_q);
            end
            if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            occ_q       <= occ_d;
            o_rsp_valid <= (occ_d != '0);
            o_rsp_rdata <= head_d;
        end
    end

`ifdef SRAM_ZERO_INIT_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            init_cnt_q <= '0;
        end else if (state_q == ST_INIT) begin
            init_cnt_q <= init_cnt_q + 1'b1;
        end
    end
`endif

    sram_tile_array #(
        .DATA_W (DATA_W),
        .ROWS   (ROWS)
    ) u_tiles (
        .clk    (i_clk),
        .row_en (row_en),
        .we     (arr_we),
        .addr   (arr_addr),
        .wdata  (arr_wdata),
        .bmask  (arr_bmask),
        .rdata  (rdata_rows)
    );

endmodule

// File: tb/tb_sram_ctrl_banked.sv
// Self-checking bench for sram_ctrl_banked (default parameters, either SRAM_ZERO_INIT_EN setting).
module tb_sram_ctrl_banked;

    localparam logic [63:0] FULL = 64'hFFFF_FFFF_FFFF_FFFF;
`ifdef SRAM_ZERO_INIT_EN
    localparam int INIT_EDGES = 128;
`else
    localparam int INIT_EDGES = 2;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic        i_req_we = 1'b0;
    logic [8:0]  i_req_addr = '0;
    logic [63:0] i_req_wdata = '0;
    logic [63:0] i_req_bmask = '0;
    logic        o_rsp_valid;
    logic        i_rsp_ready = 1'b1;
    logic [63:0] o_rsp_rdata;
    logic        o_init_done;

    int total = 0;
    int bad = 0;
    int unexp = 0;
    int n_rsp = 0;
    logic [63:0] exp_q[$];
    logic [63:0] model [512];

    typedef struct {
        logic        we;
        logic [8:0]  addr;
        logic [63:0] wdata;
        logic [63:0] bmask;
        logic [63:0] exp;
    } vec_t;
    vec_t tbl [16];

    sram_ctrl_banked dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_we    (i_req_we),
        .i_req_addr  (i_req_addr),
        .i_req_wdata (i_req_wdata),
        .i_req_bmask (i_req_bmask),
        .o_rsp_valid (o_rsp_valid),
        .i_rsp_ready (i_rsp_ready),
        .o_rsp_rdata (o_rsp_rdata),
        .o_init_done (o_init_done)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, act, exp);
        end
    endtask

    // Response scoreboard and single-row-enable monitor
    always @(negedge i_clk) begin
        if (i_rst_n && o_rsp_valid && i_rsp_ready) begin
            if (exp_q.size() == 0) begin
                unexp++;
            end else begin
                check("rsp_data", o_rsp_rdata, exp_q.pop_front());
                n_rsp++;
            end
        end
        if (i_rst_n && o_init_done && (|dut.u_tiles.row_en)) begin
            check("row_en_onehot", 64'($onehot0(dut.u_tiles.row_en)), 64'd1);
        end
    end

    task automatic issue(input logic we, input logic [8:0] a, input logic [63:0] d,
                         input logic [63:0] m, input logic [63:0] e, output int stalls);
        int n;
        n = 0;
        i_req_valid = 1'b1;
        i_req_we    = we;
        i_req_addr  = a;
        i_req_wdata = d;
        i_req_bmask = m;
        @(negedge i_clk);
        while (!o_req_ready && n < 300) begin
            n++;
            @(negedge i_clk);
        end
        stalls = n;
        if (!o_req_ready) check("req_accept_timeout", 64'd0, 64'd1);
        else if (we) model[a] = (model[a] & ~m) | (d & m);
        else exp_q.push_back(e);
        @(posedge i_clk);
        #1;
        i_req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            n++;
            @(negedge i_clk);
        end
        check("drain_left", 64'(exp_q.size()), 64'd0);
        @(posedge i_clk);
        #1;
    endtask

    task automatic reset_and_init();
        int n;
        bit got;
        i_rst_n = 1'b0;
        i_req_valid = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
`ifdef SRAM_ZERO_INIT_EN
        for (int i = 0; i < 512; i++) model[i] = '0;
`endif
        i_rst_n = 1'b1;
        n = 0;
        got = 1'b0;
        while (!got && n < 400) begin
            @(posedge i_clk);
            n++;
            @(negedge i_clk);
            if (n == 1) check("ready_during_init", 64'(o_req_ready), 64'd0);
            got = o_init_done;
        end
        check("init_edges", 64'(n), 64'(INIT_EDGES));
        check("ready_after_init", 64'(o_req_ready), 64'd1);
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        int st;
        int stall_sum;
        int acc;
        int rsp0;
        logic [63:0] held;

        tbl[0]  = '{1'b1, 9'h1A3, FULL, FULL, 64'h0};
        tbl[1]  = '{1'b1, 9'h1A3, 64'h0, 64'h0000_FFFF_0000_FFFF, 64'h0};
        tbl[2]  = '{1'b0, 9'h1A3, 64'h0, 64'h0, 64'hFFFF_0000_FFFF_0000};
        tbl[3]  = '{1'b1, 9'h07F, 64'h7F7F_0000_0000_007F, FULL, 64'h0};
        tbl[4]  = '{1'b1, 9'h080, 64'h8080_0000_0000_0080, FULL, 64'h0};
        tbl[5]  = '{1'b1, 9'h0FF, 64'h0FF0_0FF0_0000_00FF, FULL, 64'h0};
        tbl[6]  = '{1'b1, 9'h100, 64'h0100_0100_0000_0100, FULL, 64'h0};
        tbl[7]  = '{1'b1, 9'h1FF, 64'h01FF_01FF_0000_01FF, FULL, 64'h0};
        tbl[8]  = '{1'b0, 9'h07F, 64'h0, 64'h0, 64'h7F7F_0000_0000_007F};
        tbl[9]  = '{1'b0, 9'h080, 64'h0, 64'h0, 64'h8080_0000_0000_0080};
        tbl[10] = '{1'b0, 9'h0FF, 64'h0, 64'h0, 64'h0FF0_0FF0_0000_00FF};
        tbl[11] = '{1'b0, 9'h100, 64'h0, 64'h0, 64'h0100_0100_0000_0100};
        tbl[12] = '{1'b0, 9'h1FF, 64'h0, 64'h0, 64'h01FF_01FF_0000_01FF};
        tbl[13] = '{1'b1, 9'h040, 64'h0123_4567_89AB_CDEF, FULL, 64'h0};
        tbl[14] = '{1'b1, 9'h040, 64'hFEDC_BA98_7654_3210, 64'hFFFF_FFFF_0000_0000, 64'h0};
        tbl[15] = '{1'b0, 9'h040, 64'h0, 64'h0, 64'hFEDC_BA98_89AB_CDEF};

        // Outputs held at zero in reset
        #3;
        check("rst_req_ready", 64'(o_req_ready), 64'd0);
        check("rst_rsp_valid", 64'(o_rsp_valid), 64'd0);
        check("rst_rsp_rdata", o_rsp_rdata, 64'd0);
        check("rst_init_done", 64'(o_init_done), 64'd0);
        reset_and_init();

`ifdef SRAM_ZERO_INIT_EN
        for (int a = 0; a < 512; a++) issue(1'b0, 9'(a), '0, '0, 64'h0, st);
        wait_drain();
`endif

        for (int i = 0; i < 16; i++)
            issue(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].bmask, tbl[i].exp, st);
        wait_drain();

        // Write then read same address on the next cycle; response two cycles later
        issue(1'b1, 9'd5, 64'hA5A5, FULL, 64'h0, st);
        issue(1'b0, 9'd5, 64'h0, 64'h0, 64'hA5A5, st);
        @(negedge i_clk);
        check("b2b_valid_t2", 64'(o_rsp_valid), 64'd0);
        @(negedge i_clk);
        check("b2b_valid_t3", 64'(o_rsp_valid), 64'd1);
        check("b2b_data_t3", o_rsp_rdata, 64'hA5A5);
        @(posedge i_clk);
        #1;
        wait_drain();

        // Streamed reads of a full tile row with the consumer always ready
        for (int i = 0; i < 128; i++)
            issue(1'b1, 9'(i), {16'hBEEF, 16'(i), 16'hCAFE, 16'(~i)}, FULL, 64'h0, st);
        stall_sum = 0;
        rsp0 = n_rsp;
        for (int i = 0; i < 128; i++) begin
            issue(1'b0, 9'(i), 64'h0, 64'h0, {16'hBEEF, 16'(i), 16'hCAFE, 16'(~i)}, st);
            stall_sum += st;
        end
        wait_drain();
        check("stream_stalls", 64'(stall_sum), 64'd0);
        check("stream_rsp_count", 64'(n_rsp - rsp0), 64'd128);

        // Backpressure: only RSP_DEPTH reads accepted, head data held
        i_rsp_ready = 1'b0;
        i_req_valid = 1'b1;
        i_req_we    = 1'b0;
        acc = 0;
        held = '0;
        i_req_addr = 9'd10;
        for (int c = 0; c < 8; c++) begin
            @(negedge i_clk);
            if (o_req_ready) begin
                exp_q.push_back({16'hBEEF, 16'(10 + acc), 16'hCAFE, 16'(~(10 + acc))});
                acc++;
            end
            if (c == 3) held = o_rsp_rdata;
            if (c == 7) begin
                check("bp_accepts", 64'(acc), 64'd2);
                check("bp_ready_low", 64'(o_req_ready), 64'd0);
                check("bp_valid_high", 64'(o_rsp_valid), 64'd1);
                check("bp_rdata_stable", o_rsp_rdata, held);
                check("bp_head_data", o_rsp_rdata, {16'hBEEF, 16'd10, 16'hCAFE, 16'(~10)});
            end
            @(posedge i_clk);
            #1;
            i_req_addr = 9'(10 + acc);
        end
        i_rsp_ready = 1'b1;
        @(negedge i_clk);
        check("bp_ready_on_pop", 64'(o_req_ready), 64'd1);
        if (o_req_ready) exp_q.push_back({16'hBEEF, 16'(10 + acc), 16'hCAFE, 16'(~(10 + acc))});
        @(posedge i_clk);
        #1;
        i_req_valid = 1'b0;
        wait_drain();

        // Reset one cycle after a read is accepted: no response may follow
        issue(1'b1, 9'd300, 64'h3030, FULL, 64'h0, st);
        issue(1'b0, 9'd300, 64'h0, 64'h0, 64'h3030, st);
        i_rst_n = 1'b0;
        exp_q.delete();
        #2;
        check("midrst_req_ready", 64'(o_req_ready), 64'd0);
        check("midrst_rsp_valid", 64'(o_rsp_valid), 64'd0);
        check("midrst_rsp_rdata", o_rsp_rdata, 64'd0);
        check("midrst_init_done", 64'(o_init_done), 64'd0);
        reset_and_init();
        repeat (4) @(negedge i_clk);
        check("midrst_rsp_count", 64'(exp_q.size()), 64'd0);
        @(posedge i_clk);
        #1;
        issue(1'b1, 9'd300, 64'h3131, FULL, 64'h0, st);
        issue(1'b0, 9'd300, 64'h0, 64'h0, 64'h3131, st);
        wait_drain();

        check("unexpected_rsp", 64'(unexp), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
